// File: rtl/blk66_rate_adapt_if.sv
// Block-stream bundle between the source mux / rate-adapt FIFO and its neighbours.
// Widths follow the same NUM_SRC / DEPTH parameters as blk66_rate_adapt.
interface blk66_rate_adapt_if #(
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 32
);
   localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int LW = $clog2(DEPTH) + 1;

   logic [SW-1:0]          src_sel;
   logic [64*NUM_SRC-1:0]  in_dat;
   logic [2*NUM_SRC-1:0]   in_sh;
   logic [NUM_SRC-1:0]     in_val;
   logic [NUM_SRC-1:0]     in_lock;
   logic                   out_rdy;
   logic [63:0]            out_dat;
   logic [1:0]             out_sh;
   logic                   out_val;
   logic [LW-1:0]          level;
   logic [15:0]            del_cnt;
   logic [15:0]            ins_cnt;
   logic                   ovf;
   logic                   unf;
   logic                   clr_stats;

   modport master (
      output src_sel, in_dat, in_sh, in_val, in_lock, out_rdy, clr_stats,
      input  out_dat, out_sh, out_val, level, del_cnt, ins_cnt, ovf, unf
   );

   modport slave (
      input  src_sel, in_dat, in_sh, in_val, in_lock, out_rdy, clr_stats,
      output out_dat, out_sh, out_val, level, del_cnt, ins_cnt, ovf, unf
   );
endinterface

// File: rtl/blk66_rate_adapt.sv
// 66b block rate adapter: source mux, elastic FIFO with idle delete/insert at the
// watermarks, forced loss-of-sync output on underflow, saturating statistics.
module blk66_rate_adapt #(
   parameter int          NUM_SRC   = 2,
   parameter int          DEPTH     = 32,
   parameter int          HIGH_MARK = 21,
   parameter int          LOW_MARK  = 8,
   parameter logic [7:0]  IDLE_CTL  = 8'h1E
) (
   input logic               clk,
   input logic               rst_n,
   blk66_rate_adapt_if.slave bus
);
   localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_HIGH = LW'(HIGH_MARK);
   localparam logic [LW-1:0] LVL_LOW  = LW'(LOW_MARK);

   function automatic logic is_idle(input logic [1:0] sh, input logic [63:0] dat);
      return (sh == 2'b01) && (dat[7:0] == IDLE_CTL);
   endfunction

   logic [SW-1:0] sel_q, sel_d;
   logic          stg_val_q, stg_val_d;
   logic [1:0]    stg_sh_q, stg_sh_d;
   logic [63:0]   stg_dat_q, stg_dat_d;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          last_wr_idle_q, last_wr_idle_d;
   logic          last_emit_idle_q, last_emit_idle_d;

   logic          out_val_q, out_val_d;
   logic [1:0]    out_sh_q, out_sh_d;
   logic [63:0]   out_dat_q, out_dat_d;
   logic [15:0]   del_cnt_q, del_cnt_d;
   logic [15:0]   ins_cnt_q, ins_cnt_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;

   logic [65:0]   mem [DEPTH];
   logic [65:0]   head;
   logic          flush, stg_idle;
   logic          push, pop, del, ins, drop, under;

   assign head     = mem[rd_ptr_q];
   assign flush    = (bus.src_sel != sel_q);
   assign stg_idle = is_idle(stg_sh_q, stg_dat_q);

   // Input stage: out-of-lock sources are replaced by sh=00 zero blocks
   always_comb begin
      sel_d     = bus.src_sel;
      stg_val_d = 1'b0;
      stg_sh_d  = 2'b00;
      stg_dat_d = 64'h0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (bus.src_sel == SW'(k)) begin
            stg_val_d = bus.in_val[k];
            if (bus.in_lock[k]) begin
               stg_sh_d  = bus.in_sh[k*2 +: 2];
               stg_dat_d = bus.in_dat[k*64 +: 64];
            end
         end
      end
   end

   always_comb begin
      wr_ptr_d         = wr_ptr_q;
      rd_ptr_d         = rd_ptr_q;
      level_d          = level_q;
      last_wr_idle_d   = last_wr_idle_q;
      last_emit_idle_d = last_emit_idle_q;
      out_val_d        = 1'b0;
      out_sh_d         = out_sh_q;
      out_dat_d        = out_dat_q;
      del_cnt_d        = del_cnt_q;
      ins_cnt_d        = ins_cnt_q;
      ovf_d            = ovf_q;
      unf_d            = unf_q;
      push             = 1'b0;
      pop              = 1'b0;
      ins              = 1'b0;
      drop             = 1'b0;
      under            = 1'b0;

      if (bus.out_rdy) begin
         out_val_d = 1'b1;
         if ((level_q <= LVL_LOW) && last_emit_idle_q) begin
            ins              = 1'b1;
            out_sh_d         = 2'b01;
            out_dat_d        = {56'h0, IDLE_CTL};
            last_emit_idle_d = 1'b1;
         end else if (level_q != '0) begin
            pop              = 1'b1;
            out_sh_d         = head[65:64];
            out_dat_d        = head[63:0];
            last_emit_idle_d = is_idle(head[65:64], head[63:0]);
         end else begin
            under            = 1'b1;
            out_sh_d         = 2'b00;
            out_dat_d        = 64'h0;
            last_emit_idle_d = 1'b0;
         end
      end

      del = stg_val_q && stg_idle && last_wr_idle_q && (level_q >= LVL_HIGH) && !flush;
      if (stg_val_q && !del && !flush) begin
         if ((level_q != LVL_FULL) || pop) begin
            push           = 1'b1;
            last_wr_idle_d = stg_idle;
         end else begin
            drop = 1'b1;
         end
      end

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};

      // Source switch: the old stream's backlog and idle history are meaningless
      if (flush) begin
         wr_ptr_d         = '0;
         rd_ptr_d         = '0;
         level_d          = '0;
         last_wr_idle_d   = 1'b0;
         last_emit_idle_d = 1'b0;
      end

      if (bus.clr_stats) begin
         del_cnt_d = 16'h0;
         ins_cnt_d = 16'h0;
         ovf_d     = 1'b0;
         unf_d     = 1'b0;
      end else begin
         if (del && (del_cnt_q != 16'hFFFF)) del_cnt_d = del_cnt_q + 16'h1;
         if (ins && (ins_cnt_q != 16'hFFFF)) ins_cnt_d = ins_cnt_q + 16'h1;
         if (drop)  ovf_d = 1'b1;
         if (under) unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q            <= '0;
         stg_val_q        <= 1'b0;
         stg_sh_q         <= 2'b00;
         stg_dat_q        <= 64'h0;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         level_q          <= '0;
         last_wr_idle_q   <= 1'b0;
         last_emit_idle_q <= 1'b0;
         out_val_q        <= 1'b0;
         out_sh_q         <= 2'b00;
         out_dat_q        <= 64'h0;
         del_cnt_q        <= 16'h0;
         ins_cnt_q        <= 16'h0;
         ovf_q            <= 1'b0;
         unf_q            <= 1'b0;
      end else begin
         sel_q            <= sel_d;
         stg_val_q        <= stg_val_d;
         stg_sh_q         <= stg_sh_d;
         stg_dat_q        <= stg_dat_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         level_q          <= level_d;
         last_wr_idle_q   <= last_wr_idle_d;
         last_emit_idle_q <= last_emit_idle_d;
         out_val_q        <= out_val_d;
         out_sh_q         <= out_sh_d;
         out_dat_q        <= out_dat_d;
         del_cnt_q        <= del_cnt_d;
         ins_cnt_q        <= ins_cnt_d;
         ovf_q            <= ovf_d;
         unf_q            <= unf_d;
      end
   end

   // Storage is left unreset; level gating guarantees stale entries are never popped
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= {stg_sh_q, stg_dat_q};
   end

   assign bus.out_val = out_val_q;
   assign bus.out_sh  = out_sh_q;
   assign bus.out_dat = out_dat_q;
   assign bus.level   = level_q;
   assign bus.del_cnt = del_cnt_q;
   assign bus.ins_cnt = ins_cnt_q;
   assign bus.ovf     = ovf_q;
   assign bus.unf     = unf_q;
endmodule

// File: tb/tb_blk66_rate_adapt.sv
// Bench for blk66_rate_adapt (NUM_SRC=4): vector table, directed corner sequences,
// and a random run checked every cycle against a queue-based reference model.
module tb_blk66_rate_adapt;
   localparam int         NS    = 4;
   localparam int         DEPTH = 32;
   localparam int         HIGH  = 21;
   localparam int         LOW   = 8;
   localparam logic [7:0] IDLE  = 8'h1E;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   blk66_rate_adapt_if #(.NUM_SRC(NS), .DEPTH(DEPTH)) bus ();

   blk66_rate_adapt #(
      .NUM_SRC(NS), .DEPTH(DEPTH), .HIGH_MARK(HIGH), .LOW_MARK(LOW), .IDLE_CTL(IDLE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [65:0] data_blk(input int n);
      return {2'b10, 48'(n), 8'h5A, 8'hA5};
   endfunction
   function automatic logic [65:0] idle_blk(input int n);
      return {2'b01, 48'(n), 8'h00, IDLE};
   endfunction
   function automatic logic [65:0] src_blk(input int k, input int n);
      return {2'b10, 8'(k), 48'(n), 8'hA5};
   endfunction

   // ---------------- reference model ----------------
   logic [65:0] m_q[$];
   logic        m_lwi, m_lei, m_stg_val, m_oval, m_ovf, m_unf;
   logic [65:0] m_stg, m_out;
   logic [1:0]  m_sel;
   int          m_del, m_ins;

   function automatic logic idle66(input logic [65:0] b);
      return (b[65:64] == 2'b01) && (b[7:0] == IDLE);
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_lwi = 0; m_lei = 0; m_stg_val = 0; m_oval = 0; m_ovf = 0; m_unf = 0;
      m_stg = '0; m_out = '0; m_sel = '0; m_del = 0; m_ins = 0;
   endtask

   task automatic model_step(input logic [1:0] sel, input logic [NS-1:0] val,
                             input logic [NS-1:0] lock, input logic [2*NS-1:0] sh,
                             input logic [64*NS-1:0] dat, input logic rdy, input logic clr);
      int lvl;
      int s;
      bit flush, pop, del, ins, und, drop;
      lvl = m_q.size();
      s = int'(sel);
      flush = (sel != m_sel);
      pop = 0; ins = 0; und = 0; drop = 0;
      if (rdy) begin
         if (lvl <= LOW && m_lei) begin m_out = {2'b01, 56'h0, IDLE}; ins = 1; end
         else if (lvl > 0) begin m_out = m_q[0]; pop = 1; end
         else begin m_out = '0; und = 1; end
         m_lei = idle66(m_out);
      end
      m_oval = rdy;
      del = m_stg_val && idle66(m_stg) && m_lwi && (lvl >= HIGH) && !flush;
      if (pop) void'(m_q.pop_front());
      if (m_stg_val && !del && !flush) begin
         if (lvl < DEPTH || pop) begin m_q.push_back(m_stg); m_lwi = idle66(m_stg); end
         else drop = 1;
      end
      if (flush) begin m_q.delete(); m_lwi = 0; m_lei = 0; end
      if (clr) begin m_del = 0; m_ins = 0; m_ovf = 0; m_unf = 0; end
      else begin
         if (del && m_del < 65535) m_del++;
         if (ins && m_ins < 65535) m_ins++;
         if (drop) m_ovf = 1;
         if (und)  m_unf = 1;
      end
      m_stg_val = val[s];
      m_stg = lock[s] ? {sh[s*2 +: 2], dat[s*64 +: 64]} : '0;
      m_sel = sel;
   endtask

   // One clock: model advances on the pre-edge inputs, DUT sampled 2ns after the edge
   task automatic tick();
      logic [1:0] c_sel;
      logic [NS-1:0] c_val, c_lock;
      logic [2*NS-1:0] c_sh;
      logic [64*NS-1:0] c_dat;
      logic c_rdy, c_clr;
      c_sel = bus.src_sel; c_val = bus.in_val; c_lock = bus.in_lock;
      c_sh = bus.in_sh; c_dat = bus.in_dat; c_rdy = bus.out_rdy; c_clr = bus.clr_stats;
      @(posedge clk);
      model_step(c_sel, c_val, c_lock, c_sh, c_dat, c_rdy, c_clr);
      #2;
      check("mdl.level",   64'(bus.level),   64'(m_q.size()));
      check("mdl.out_val", 64'(bus.out_val), 64'(m_oval));
      check("mdl.out_sh",  64'(bus.out_sh),  64'(m_out[65:64]));
      check("mdl.out_dat", bus.out_dat,      m_out[63:0]);
      check("mdl.del_cnt", 64'(bus.del_cnt), 64'(m_del));
      check("mdl.ins_cnt", 64'(bus.ins_cnt), 64'(m_ins));
      check("mdl.ovf",     64'(bus.ovf),     64'(m_ovf));
      check("mdl.unf",     64'(bus.unf),     64'(m_unf));
   endtask

   task automatic set_src(input int k, input logic v, input logic [65:0] b, input logic lk);
      bus.in_val[k] = v;
      bus.in_sh[k*2 +: 2] = b[65:64];
      bus.in_dat[k*64 +: 64] = b[63:0];
      bus.in_lock[k] = lk;
   endtask

   task automatic do_reset(input bit chk);
      #3 rst_n = 1'b0;
      #1;
      if (chk) begin
         check("rst.out_val", 64'(bus.out_val), 64'd0);
         check("rst.out_sh",  64'(bus.out_sh),  64'd0);
         check("rst.out_dat", bus.out_dat,      64'd0);
         check("rst.level",   64'(bus.level),   64'd0);
         check("rst.del_cnt", 64'(bus.del_cnt), 64'd0);
         check("rst.ins_cnt", 64'(bus.ins_cnt), 64'd0);
         check("rst.ovf",     64'(bus.ovf),     64'd0);
         check("rst.unf",     64'(bus.unf),     64'd0);
      end
      model_reset();
      bus.src_sel = '0; bus.in_val = '0; bus.in_lock = '1; bus.in_sh = '0; bus.in_dat = '0;
      bus.out_rdy = 1'b0; bus.clr_stats = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   typedef struct {
      logic val; logic idle; logic rdy; logic clr;
      int lvl; logic oval; logic [1:0] osh; logic [7:0] olo; logic unf; int ins;
   } vec_t;
   vec_t tv[9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [65:0] eb;
      bus.src_sel = '0; bus.in_val = '0; bus.in_lock = '1; bus.in_sh = '0; bus.in_dat = '0;
      bus.out_rdy = 1'b0; bus.clr_stats = 1'b0;

      // ---- table: val idle rdy clr | level out_val out_sh dat[7:0] unf ins_cnt ----
      tv[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 2'b00, 8'h00, 1'b1, 0};
      tv[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 2'b00, 8'h00, 1'b0, 0};
      tv[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2'b00, 8'h00, 1'b0, 0};
      tv[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 2'b00, 8'h00, 1'b0, 0};
      tv[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0, 2'b00, 8'h00, 1'b0, 0};
      tv[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 2'b10, 8'hA5, 1'b0, 0};
      tv[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 2'b01, 8'h1E, 1'b0, 0};
      tv[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 2'b01, 8'h1E, 1'b0, 1};
      tv[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 2'b01, 8'h1E, 1'b0, 1};

      do_reset(1'b0);
      for (int r = 0; r < 9; r++) begin
         set_src(0, tv[r].val, tv[r].idle ? idle_blk(r) : data_blk(r), 1'b1);
         bus.out_rdy = tv[r].rdy;
         bus.clr_stats = tv[r].clr;
         tick();
         check("tv.level",   64'(bus.level),       64'(tv[r].lvl));
         check("tv.out_val", 64'(bus.out_val),     64'(tv[r].oval));
         check("tv.out_sh",  64'(bus.out_sh),      64'(tv[r].osh));
         check("tv.dat_lo",  64'(bus.out_dat[7:0]), 64'(tv[r].olo));
         check("tv.unf",     64'(bus.unf),         64'(tv[r].unf));
         check("tv.ins_cnt", 64'(bus.ins_cnt),     64'(tv[r].ins));
      end

      // ---- idle deletion at the high watermark ----
      do_reset(1'b0);
      for (int i = 1; i <= 25; i++) begin
         set_src(0, i <= 24, (i == 22 || i == 23) ? idle_blk(i) : data_blk(i), 1'b1);
         bus.out_rdy = (i == 23);
         tick();
         if (i == 22) check("del.fill_level", 64'(bus.level), 64'd21);
         if (i == 24) begin
            check("del.level_hold", 64'(bus.level), 64'd21);
            check("del.cnt", 64'(bus.del_cnt), 64'd1);
         end
         if (i == 25) check("del.level_after", 64'(bus.level), 64'd22);
      end

      // ---- idle insertion at the low watermark ----
      do_reset(1'b0);
      for (int i = 1; i <= 12; i++) begin
         set_src(0, i <= 9, (i == 1) ? idle_blk(i) : data_blk(i), 1'b1);
         bus.out_rdy = (i >= 11);
         tick();
         if (i == 10) check("ins.level9", 64'(bus.level), 64'd9);
         if (i == 11) begin
            check("ins.pop_level", 64'(bus.level), 64'd8);
            check("ins.pop_sh", 64'(bus.out_sh), 64'd1);
         end
         if (i == 12) begin
            check("ins.out_val", 64'(bus.out_val), 64'd1);
            check("ins.out_sh", 64'(bus.out_sh), 64'd1);
            check("ins.out_dat", bus.out_dat, 64'h1E);
            check("ins.level", 64'(bus.level), 64'd8);
            check("ins.cnt", 64'(bus.ins_cnt), 64'd1);
         end
      end

      // ---- overflow at full, clr priority, push+pop at full ----
      do_reset(1'b0);
      for (int i = 1; i <= 36; i++) begin
         set_src(0, 1'b1, data_blk(i), 1'b1);
         bus.out_rdy = (i == 36);
         bus.clr_stats = (i == 35);
         tick();
         if (i == 33) check("ovf.full", 64'(bus.level), 64'd32);
         if (i == 34) begin
            check("ovf.level", 64'(bus.level), 64'd32);
            check("ovf.set", 64'(bus.ovf), 64'd1);
         end
         if (i == 35) check("ovf.clr_prio", 64'(bus.ovf), 64'd0);
         if (i == 36) begin
            eb = data_blk(1);
            check("ovf.pp_level", 64'(bus.level), 64'd32);
            check("ovf.pp_flag", 64'(bus.ovf), 64'd0);
            check("ovf.pp_head", bus.out_dat, eb[63:0]);
         end
      end

      // ---- source switch flush, then out-of-lock zero block ----
      do_reset(1'b0);
      for (int i = 1; i <= 20; i++) begin
         bus.src_sel = (i <= 11) ? 2'd0 : 2'd3;
         set_src(0, i != 11, src_blk(0, i), 1'b1);
         set_src(3, i <= 15, src_blk(3, i), i != 15);
         bus.out_rdy = (i >= 17);
         tick();
         if (i == 11) check("sw.level10", 64'(bus.level), 64'd10);
         if (i == 12) check("sw.flush", 64'(bus.level), 64'd0);
         if (i == 16) check("sw.level4", 64'(bus.level), 64'd4);
         if (i >= 17 && i <= 19) begin
            eb = src_blk(3, i - 5);
            check("sw.src3_dat", bus.out_dat, eb[63:0]);
            check("sw.src3_sh", 64'(bus.out_sh), 64'd2);
         end
         if (i == 20) begin
            check("sw.nolock_sh", 64'(bus.out_sh), 64'd0);
            check("sw.nolock_dat", bus.out_dat, 64'd0);
            check("sw.nolock_val", 64'(bus.out_val), 64'd1);
            check("sw.nolock_unf", 64'(bus.unf), 64'd0);
         end
      end

      // ---- asynchronous reset mid-stream at level 15 ----
      do_reset(1'b0);
      for (int i = 1; i <= 17; i++) begin
         set_src(0, i <= 16, data_blk(i), 1'b1);
         bus.out_rdy = (i == 1 || i == 17);
         tick();
      end
      check("mid.level15", 64'(bus.level), 64'd15);
      check("mid.unf", 64'(bus.unf), 64'd1);
      do_reset(1'b1);

      // ---- randomized run against the model ----
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 199) == 0) bus.src_sel = 2'($urandom_range(0, NS - 1));
         for (int k = 0; k < NS; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4)       eb = {2'b01, 24'($urandom), $urandom, IDLE};
            else if (r == 4) eb = {2'b01, 24'($urandom), $urandom, 8'($urandom)};
            else             eb = {2'b10, $urandom, $urandom};
            set_src(k, $urandom_range(0, 99) < 80, eb, $urandom_range(0, 19) != 0);
         end
         bus.out_rdy = $urandom_range(0, 99) < (((c / 150) % 2 == 1) ? 90 : 35);
         bus.clr_stats = ($urandom_range(0, 149) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
